muxn_pipe: RTL and testbench



---
 rtl/muxn_pkg.sv | 16 +
 rtl/muxn_stage_reg.sv | 27 ++
 rtl/muxn_pipe.sv | 102 ++++++++++
 tb/tb_muxn_pipe.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared definitions for the registered N-way selector and other pipeline registers.
package muxn_pkg;

    localparam int unsigned MAX_N      = 16;
    localparam int unsigned MAX_STAGES = 4;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctl_t;

    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/muxn_stage_reg.sv
// One pipeline register: reset and clear zero it, hold freezes it, otherwise it loads.
module muxn_stage_reg #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (!hold_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/muxn_pipe.sv
// N-input select feeding a STAGES-deep valid-tracked register pipeline with
// stall/flush control and a sticky out-of-range select flag.
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter  int unsigned WIDTH  = 64,
    parameter  int unsigned N      = 4,
    parameter  int unsigned STAGES = 1,
    localparam int unsigned SEL_W  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               sel_err
);

    localparam int unsigned LEAVES = 1 << SEL_W;

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("muxn_pipe: N out of range");
    end
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("muxn_pipe: STAGES out of range");
    end

    pipe_ctl_t ctl;
    assign ctl.stall = stall;
    assign ctl.flush = flush;

    // Binary select tree; level l consumes sel[l-1], padded leaves are zero.
    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        localparam int unsigned CNT = LEAVES >> l;
        logic [WIDTH-1:0] node [CNT];
        for (genvar j = 0; j < CNT; j++) begin : g_n
            if (l == 0) begin : g_leaf
                if (j < N) begin : g_used
                    assign node[j] = in[j*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign node[j] = '0;
                end
            end else begin : g_mux
                assign node[j] = sel[l-1] ? g_lvl[l-1].node[2*j+1] : g_lvl[l-1].node[2*j];
            end
        end
    end

    logic [WIDTH-1:0] tree_out;
    logic             sel_ok;
    assign tree_out = g_lvl[SEL_W].node[0];

    if (is_pow2(N)) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_chk
        assign sel_ok = (SEL_W+1)'(sel) < (SEL_W+1)'(N);
    end

    logic [WIDTH:0] stage_d [STAGES];
    logic [WIDTH:0] stage_q [STAGES];

    assign stage_d[0] = {in_valid, (in_valid && sel_ok) ? tree_out : WIDTH'(0)};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s > 0) begin : g_link
            assign stage_d[s] = stage_q[s-1];
        end
        muxn_stage_reg #(
            .W(WIDTH + 1)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear_i (ctl.flush),
            .hold_i  (ctl.stall),
            .d_i     (stage_d[s]),
            .q_o     (stage_q[s])
        );
    end

    assign out       = stage_q[STAGES-1][WIDTH-1:0];
    assign out_valid = stage_q[STAGES-1][WIDTH];

    // Sticky flag: only advance edges can set it, only reset clears it.
    if (is_pow2(N)) begin : g_err_none
        assign sel_err = 1'b0;
    end else begin : g_err_reg
        logic sel_err_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                sel_err_q <= 1'b0;
            end else if (!ctl.flush && !ctl.stall && in_valid && !sel_ok) begin
                sel_err_q <= 1'b1;
            end
        end
        assign sel_err = sel_err_q;
    end

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed bench for muxn_pipe: a 4-way/2-stage and a 3-way/1-stage instance
// checked against queue scoreboards of the expected stage contents.
module tb_muxn_pipe;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_in_valid, a_stall, a_flush;
    logic [31:0] a_in;
    logic [1:0]  a_sel;
    logic [7:0]  a_out;
    logic        a_out_valid, a_sel_err;

    logic        b_reset, b_in_valid, b_stall, b_flush;
    logic [23:0] b_in;
    logic [1:0]  b_sel;
    logic [7:0]  b_out;
    logic        b_out_valid, b_sel_err;

    muxn_pipe #(.WIDTH(8), .N(4), .STAGES(2)) u_dut_a (
        .clk(clk), .reset(a_reset), .in(a_in), .sel(a_sel), .in_valid(a_in_valid),
        .stall(a_stall), .flush(a_flush), .out(a_out), .out_valid(a_out_valid),
        .sel_err(a_sel_err)
    );

    muxn_pipe #(.WIDTH(8), .N(3), .STAGES(1)) u_dut_b (
        .clk(clk), .reset(b_reset), .in(b_in), .sel(b_sel), .in_valid(b_in_valid),
        .stall(b_stall), .flush(b_flush), .out(b_out), .out_valid(b_out_valid),
        .sel_err(b_sel_err)
    );

    ent_t qa[$];
    ent_t qb[$];
    logic exp_err_a, exp_err_b;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic logic [7:0] chan(input int k);
        return 8'((k + 1) * 8'h11);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed 0x%0h expected 0x%0h", tag, step_no, obs, exp);
        end
    endtask

    // N=4, STAGES=2 instance; qa[0] models the final stage.
    task automatic step_a(input logic rs, input logic v, input int s, input logic st, input logic fl);
        ent_t e;
        @(negedge clk);
        a_reset = rs; a_in_valid = v; a_sel = 2'(s); a_stall = st; a_flush = fl;
        @(posedge clk);
        step_no++;
        if (rs || fl) begin
            for (int i = 0; i < 2; i++) qa[i] = '0;
            if (rs) exp_err_a = 1'b0;
        end else if (!st) begin
            e.v = v;
            e.d = (v && s < 4) ? chan(s) : 8'h00;
            void'(qa.pop_front());
            qa.push_back(e);
            if (v && s >= 4) exp_err_a = 1'b1;
        end
        #1;
        check("a_out", a_out, qa[0].d);
        check("a_out_valid", 8'(a_out_valid), 8'(qa[0].v));
        check("a_sel_err", 8'(a_sel_err), 8'(exp_err_a));
    endtask

    // N=3, STAGES=1 instance.
    task automatic step_b(input logic rs, input logic v, input int s, input logic st, input logic fl);
        ent_t e;
        @(negedge clk);
        b_reset = rs; b_in_valid = v; b_sel = 2'(s); b_stall = st; b_flush = fl;
        @(posedge clk);
        step_no++;
        if (rs || fl) begin
            qb[0] = '0;
            if (rs) exp_err_b = 1'b0;
        end else if (!st) begin
            e.v = v;
            e.d = (v && s < 3) ? chan(s) : 8'h00;
            void'(qb.pop_front());
            qb.push_back(e);
            if (v && s >= 3) exp_err_b = 1'b1;
        end
        #1;
        check("b_out", b_out, qb[0].d);
        check("b_out_valid", 8'(b_out_valid), 8'(qb[0].v));
        check("b_sel_err", 8'(b_sel_err), 8'(exp_err_b));
    endtask

    initial begin
        a_reset = 1'b1; a_in_valid = 1'b1; a_sel = 2'd0; a_stall = 1'b0; a_flush = 1'b0;
        a_in = {8'h44, 8'h33, 8'h22, 8'h11};
        b_reset = 1'b1; b_in_valid = 1'b0; b_sel = 2'd0; b_stall = 1'b0; b_flush = 1'b0;
        b_in = {8'h33, 8'h22, 8'h11};
        qa.push_back('0); qa.push_back('0);
        qb.push_back('0);
        exp_err_a = 1'b0;
        exp_err_b = 1'b0;

        // Reset held with valid input present.
        for (int i = 0; i < 3; i++) step_a(1'b1, 1'b1, 0, 1'b0, 1'b0);

        // Back-to-back stream, then drain.
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, i, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step_a(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Stall holds the pipe; inputs during stall are dropped.
        step_a(1'b0, 1'b1, 1, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 3, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step_a(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Flush wins over stall; nothing stale emerges afterwards.
        step_a(1'b0, 1'b1, 3, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 0, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1, 1'b0, 1'b0);

        // Reset mid-stream discards in-flight items.
        step_a(1'b0, 1'b1, 2, 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 1, 1'b0, 1'b0);
        step_a(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Three-way instance: out-of-range select and sticky flag.
        for (int i = 0; i < 2; i++) step_b(1'b1, 1'b1, 3, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 3, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step_b(1'b0, 1'b1, i, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 3, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 2, 1'b1, 1'b0);
        step_b(1'b0, 1'b1, 3, 1'b1, 1'b0);
        step_b(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 3, 1'b1, 1'b1);
        step_b(1'b0, 1'b1, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
